argmax_stage: RTL and testbench
===============================

# argmax_stage

Streaming arg-max classifier placed directly downstream of a fully connected layer (for example `layer_8_4_1_16`) at the end of the network. It consumes each K-word output vector from the layer over a valid/ready handshake and reports the index and value of the largest element. Its result is a single registered word pair with backpressure, so the layer can start on the next vector while the current result is still waiting.

## Interface
- `K`, default 8: words per input vector; must match the upstream layer's M; K ≥ 1.
- `T`, default 16: word width; matches the upstream layer's T.
- `logK`, default `$clog2(K)` (minimum 1): width of the index and the word counter.

- `clk`, input, 1: the single clock; all logic is on posedge.
- `reset`, input, 1: synchronous, active-high.
- `s_valid`, input, 1: `data_in` is valid.
- `s_ready`, output, 1: the block accepts `data_in` this cycle.
- `data_in`, input, T: signed vector element, in index order 0..K-1.
- `m_valid`, output, 1: `idx_out` and `max_out` hold a result.
- `m_ready`, input, 1: the consumer takes the result this cycle.
- `idx_out`, output, logK: index of the maximum element.
- `max_out`, output, T: signed maximum value.

## Operation
- An input transfer occurs when `s_valid && s_ready`. An output transfer occurs when `m_valid && m_ready`.
- Word counter `cnt` counts 0..K-1, advances only on an input transfer, and wraps to 0 after the word at K-1.
- Running registers `best` (T bits) and `best_idx` (logK bits):
  - On the transfer at `cnt == 0`, they load `data_in` and 0 unconditionally.
  - On any later transfer, they update only if `data_in > best` as a strict signed compare.
  - Ties keep the lower index.
- Final transfer (`cnt == K-1`):
  - The output registers load the winner of `best` against `data_in`, using the same rule.
  - `m_valid` goes to 1 on the next cycle.
  - `best` and `best_idx` are don't-care afterwards.
- When K=1, every accepted word is both first and last. The result is `idx_out = 0`, `max_out = data_in`.
- `s_ready = !reset && !(cnt == K-1 && m_valid && !m_ready)`.
  - Only the last word of a vector can stall, and only while an undrained result is pending.
  - Words 0..K-2 of the next vector are accepted freely.
- `m_valid` and the output registers:
  - Hold stable while `m_valid && !m_ready`.
  - Clear `m_valid` after an output transfer, unless a new last word is accepted in the same cycle.
- Simultaneous output transfer and last-word transfer: the new result loads and `m_valid` stays 1, with no bubble cycle.
- There is no arithmetic beyond the comparison and no saturation. Values pass through unchanged.

## Timing
- Reset values: `m_valid` = 0, `idx_out` = 0, `max_out` = 0, `cnt` = 0, `best` = 0, `best_idx` = 0. `s_ready` is 0 during any cycle in which `reset` is high.
- Reset mid-vector discards any partial vector and any pending result. The first transfer after reset is index 0.
- Latency: the result is visible with `m_valid = 1` on the cycle after the last word is accepted.
- Throughput: one word per cycle, with no idle cycles between vectors, provided the consumer drains each result within K-1 cycles.
- `s_ready` depends combinationally on `m_ready`. There is no combinational path from `s_valid` to any output.
- `m_valid`, `idx_out` and `max_out` are driven directly from registers.

## Structure
- Shared package `nn_pkg` holds:
  - the word width T;
  - the signed word typedef `word_t`, shared with the layer blocks.
- Sub-module `argmax_cmp`: combinational selection of the larger of two (value, index) pairs, using a strict signed compare with ties keeping the first operand.
  - It is used for both the running update and the final selection.
- The top level contains the counter, the running registers, the output register and the handshake logic.

## Test plan
1. Backpressure-free input [3,9,2,9,0,1,5,4] with `m_ready` held at 1 → `idx_out = 1`, `max_out = 9`. `m_valid` is high for exactly one cycle, 1 cycle after the 8th word.
2. Negative input [-5,-2,-7,-3,-9,-2,-8,-6] → `idx_out = 1`, `max_out = 16'hFFFE`. The signed compare and the tie rule both hold.
3. Hold the first result with `m_ready = 0` and stream the second vector [0,0,0,0,0,0,0,1]:
   - Seven words are accepted.
   - `s_ready` is 0 at the 8th word.
   - `idx_out = 1`, `max_out = 9` stay stable.
   - Pulse `m_ready` → the 8th word is accepted in that same cycle, and the next result is `idx_out = 7`, `max_out = 1`.
4. Back-to-back vectors with `m_ready = 1` and `s_valid` held high for 3 vectors → `m_valid` rises on the cycle after each vector's 8th word and stays continuously high in overlap cases. Exactly 3 results are delivered, with no duplicate or dropped result.
5. Assert `reset` for 1 cycle after 3 words of [50,…] → no result is produced from the partial vector. The next full vector [1,2,3,4,5,6,7,8] yields `idx_out = 7`, `max_out = 8`.
6. Random vectors interleaved with random `s_valid`/`m_ready` gaps, compared against a scoreboard model → every result matches, and outputs never change while `m_valid && !m_ready`.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types for the network tail: word width and the signed word type
// used by the layer blocks and the arg-max stage.
package nn_pkg;

  localparam int NN_T = 16;

  typedef logic signed [NN_T-1:0] word_t;

  // Index/counter width for a K-word vector; never narrower than one bit.
  function automatic int idx_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Picks the larger of two (value, index) pairs; the first operand wins ties,
// so an earlier index is kept when values are equal.
module argmax_cmp #(
  parameter int T  = 16,
  parameter int IW = 3
) (
  input  logic signed [T-1:0]  a_val,
  input  logic        [IW-1:0] a_idx,
  input  logic signed [T-1:0]  b_val,
  input  logic        [IW-1:0] b_idx,
  output logic signed [T-1:0]  y_val,
  output logic        [IW-1:0] y_idx
);

  logic take_b;

  assign take_b = (b_val > a_val);
  assign y_val  = take_b ? b_val : a_val;
  assign y_idx  = take_b ? b_idx : a_idx;

endmodule

// File: rtl/argmax_stage.sv
// Streaming arg-max over K-word vectors with a single registered result
// slot; the next vector streams in while the previous result waits.
module argmax_stage
  import nn_pkg::*;
#(
  parameter int K    = 8,
  parameter int T    = NN_T,
  parameter int logK = idx_width(K)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] data_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [logK-1:0]     idx_out,
  output logic signed [T-1:0] max_out
);

  localparam logic [logK-1:0] LAST = logK'(K - 1);

  logic [logK-1:0]     cnt;
  logic [logK-1:0]     best_idx;
  logic signed [T-1:0] best;

  logic [logK-1:0]     sel_idx;
  logic signed [T-1:0] sel_val;
  logic [logK-1:0]     win_idx;
  logic signed [T-1:0] win_val;

  logic first;
  logic last;
  logic s_xfer;
  logic m_xfer;

  assign first  = (cnt == '0);
  assign last   = (cnt == LAST);
  // Only the closing word can stall, and only behind an undrained result.
  assign s_ready = !reset && !(last && m_valid && !m_ready);
  assign s_xfer  = s_valid && s_ready;
  assign m_xfer  = m_valid && m_ready;

  argmax_cmp #(
    .T  (T),
    .IW (logK)
  ) u_cmp (
    .a_val (best),
    .a_idx (best_idx),
    .b_val (data_in),
    .b_idx (cnt),
    .y_val (sel_val),
    .y_idx (sel_idx)
  );

  // The first word of a vector seeds the running pair regardless of history;
  // with K=1 that word is also the result.
  assign win_val = first ? data_in : sel_val;
  assign win_idx = first ? '0      : sel_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      best     <= '0;
      best_idx <= '0;
      m_valid  <= 1'b0;
      idx_out  <= '0;
      max_out  <= '0;
    end else begin
      if (s_xfer) begin
        best     <= win_val;
        best_idx <= win_idx;
        cnt      <= last ? '0 : cnt + logK'(1);
        if (last) begin
          idx_out <= win_idx;
          max_out <= win_val;
        end
      end
      if (s_xfer && last) begin
        m_valid <= 1'b1;
      end else if (m_xfer) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_argmax_stage.sv
// Directed and randomised checks of argmax_stage against a queue-based
// reference that sees every input and output transfer.
module tb_argmax_stage;
  import nn_pkg::*;

  localparam int K  = 8;
  localparam int T  = NN_T;
  localparam int LK = idx_width(K);

  typedef struct {
    logic [LK-1:0] idx;
    word_t         val;
  } res_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  word_t         data_in;
  logic          m_valid;
  logic          m_ready;
  logic [LK-1:0] idx_out;
  word_t         max_out;

  int tests   = 0;
  int fails   = 0;
  int results = 0;

  res_t  exp_q[$];
  word_t part[$];
  logic  armed = 1'b0;
  logic  hold  = 1'b0;
  logic [LK-1:0] h_idx;
  word_t h_val;
  logic  rnd_on = 1'b0;

  always #5 clk = ~clk;

  argmax_stage #(.K(K), .T(T)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .data_in (data_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .idx_out (idx_out),
    .max_out (max_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: index of the first occurrence of the largest signed value.
  function automatic res_t ref_argmax(input word_t v[$]);
    res_t r;
    r.idx = '0;
    r.val = v[0];
    for (int i = 1; i < v.size(); i++) begin
      if (v[i] > r.val) begin
        r.val = v[i];
        r.idx = LK'(i);
      end
    end
    return r;
  endfunction

  // Compare process: outputs against the reference on every cycle, then
  // apply this cycle's transfers to the reference.
  always @(negedge clk) begin
    if (reset) begin
      armed = 1'b1;
      chk("s_ready_in_reset", {31'b0, s_ready}, 32'd0);
    end
    if (armed && !reset) begin
      chk("m_valid", {31'b0, m_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        chk("idx_out", 32'(idx_out), 32'(exp_q[0].idx));
        chk("max_out", 32'(max_out[T-1:0]), 32'(exp_q[0].val[T-1:0]));
      end
      chk("s_ready", {31'b0, s_ready},
          {31'b0, !(part.size() == K-1 && exp_q.size() != 0 && !m_ready)});
      if (hold) begin
        chk("hold_valid", {31'b0, m_valid}, 32'd1);
        chk("hold_idx", 32'(idx_out), 32'(h_idx));
        chk("hold_max", 32'(max_out[T-1:0]), 32'(h_val[T-1:0]));
      end
    end
    hold  = armed && !reset && m_valid && !m_ready;
    h_idx = idx_out;
    h_val = max_out;
    if (armed) begin
      if (reset) begin
        exp_q.delete();
        part.delete();
      end else begin
        if (m_valid && m_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          results++;
        end
        if (s_valid && s_ready) begin
          part.push_back(data_in);
          if (part.size() == K) begin
            exp_q.push_back(ref_argmax(part));
            part.delete();
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the word.
  task automatic send_word(input word_t w);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1;
    data_in = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_vec(input word_t v[$]);
    foreach (v[i]) send_word(v[i]);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t v1[$], v2[$], v3[$], va[$], vb[$], vc[$], vr[$];
    res_t  r;
    int    r0;

    v1 = '{3, 9, 2, 9, 0, 1, 5, 4};
    v2 = '{-5, -2, -7, -3, -9, -2, -8, -6};
    v3 = '{1, 2, 3, 4, 5, 6, 7, 8};
    va = '{8, 7, 6, 5, 4, 3, 2, 1};
    vb = '{4, 4, 9, 0, 9, -1, 9, 3};
    vc = '{-1, -1, -1, -1, -1, -1, -1, -1};

    // Pin the reference with hand-computed answers.
    r = ref_argmax(v1);
    chk("ref_v1_idx", 32'(r.idx), 32'd1);
    chk("ref_v1_val", 32'(r.val[T-1:0]), 32'd9);
    r = ref_argmax(v2);
    chk("ref_v2_idx", 32'(r.idx), 32'd1);
    chk("ref_v2_val", 32'(r.val[T-1:0]), 32'hFFFE);
    r = ref_argmax(vb);
    chk("ref_vb_idx", 32'(r.idx), 32'd2);

    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_idx", 32'(idx_out), 32'd0);
    chk("rst_max", 32'(max_out[T-1:0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_s_ready_after", {31'b0, s_ready}, 32'd1);
    step();

    // 1: no backpressure, single-cycle result pulse
    m_ready = 1'b1;
    send_vec(v1);
    chk("t1_valid", {31'b0, m_valid}, 32'd1);
    chk("t1_idx", 32'(idx_out), 32'd1);
    chk("t1_max", 32'(max_out[T-1:0]), 32'd9);
    step();
    chk("t1_pulse", {31'b0, m_valid}, 32'd0);

    // 2: negative values, tie at indices 1 and 5
    send_vec(v2);
    chk("t2_idx", 32'(idx_out), 32'd1);
    chk("t2_max", 32'(max_out[T-1:0]), 32'hFFFE);
    step();

    // 3: held result stalls only the closing word of the next vector
    m_ready = 1'b0;
    send_vec(v1);
    chk("t3_first_idx", 32'(idx_out), 32'd1);
    for (int i = 0; i < 7; i++) send_word(0);
    s_valid = 1'b1; data_in = 1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall", {31'b0, s_ready}, 32'd0);
    end
    chk("t3_hold_idx", 32'(idx_out), 32'd1);
    chk("t3_hold_max", 32'(max_out[T-1:0]), 32'd9);
    step();
    m_ready = 1'b1;
    @(negedge clk);
    chk("t3_release", {31'b0, s_ready}, 32'd1);
    step();
    s_valid = 1'b0;
    chk("t3_valid", {31'b0, m_valid}, 32'd1);
    chk("t3_idx", 32'(idx_out), 32'd7);
    chk("t3_max", 32'(max_out[T-1:0]), 32'd1);
    step();
    chk("t3_drained", {31'b0, m_valid}, 32'd0);

    // 4: three vectors back to back
    r0 = results;
    send_vec(va);
    send_vec(vb);
    send_vec(vc);
    chk("t4_last_idx", 32'(idx_out), 32'd0);
    chk("t4_last_max", 32'(max_out[T-1:0]), 32'hFFFF);
    repeat (3) step();
    chk("t4_count", 32'(results - r0), 32'd3);

    // 5: reset discards a partial vector
    send_word(50); send_word(51); send_word(52);
    reset = 1'b1;
    step();
    reset = 1'b0;
    r0 = results;
    send_vec(v3);
    chk("t5_idx", 32'(idx_out), 32'd7);
    chk("t5_max", 32'(max_out[T-1:0]), 32'd8);
    step();
    chk("t5_count", 32'(results - r0), 32'd1);

    // 6: random data with random source gaps and sink stalls
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    r0 = results;
    for (int v = 0; v < 20; v++) begin
      for (int i = 0; i < K; i++) begin
        int g, d;
        g = $urandom_range(0, 2);
        repeat (g) step();
        d = $urandom_range(0, 15);
        send_word(word_t'(d - 8));
      end
    end
    rnd_on = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    m_ready = 1'b1;
    repeat (4) step();
    chk("t6_count", 32'(results - r0), 32'd20);
    chk("t6_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
